// File: rtl/bcd_digit_formatter.sv
`timescale 1ns/1ps
// bcd_digit_formatter
// Iterative double-dabble binary-to-BCD converter for the seven-segment scan
// driver. One input bit is consumed per clock; results are committed all at
// once so the display never shows a half-converted number.
module bcd_digit_formatter #(
    parameter int IN_WIDTH = 27
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] in_value,
    input  logic                in_load,
    output logic                in_ready,
    output logic [31:0]         output_data,
    output logic [7:0]          output_valid,
    output logic                overflow,
    output logic                done
);

    localparam int          CNT_W   = $clog2(IN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = 64'd99_999_999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                w_accept;
    logic                w_shiftEn;
    logic                w_commit;
    logic                w_tooBig;
    logic [IN_WIDTH-1:0] r_shift;
    logic [31:0]         r_work;
    logic [CNT_W-1:0]    r_count;
    logic                r_sat;
    logic [30:0]         w_adj;
    logic [31:0]         w_workNext;
    logic [7:0]          w_mask;

    // Values that cannot be shown on eight digits are flagged at acceptance
    assign w_tooBig = (64'(in_value) > MAX_VAL);
    assign in_ready = (r_state == IDLE);

    // State register; reset aborts any conversion in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and one-hot datapath strobes for each phase
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_shiftEn   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_load) begin
                    w_accept    = 1'b1;
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                w_shiftEn = 1'b1;
                if (r_count == CNT_W'(1)) begin
                    w_nextState = COMMIT;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Add-3 correction on every nibble >= 5; the top bit of digit 7 is
    // shifted out and discarded, so only its low three bits are kept
    always_comb begin
        logic [3:0] v_nib;
        w_adj = '0;
        v_nib = '0;
        for (int i = 0; i < 7; i++) begin
            v_nib = r_work[4*i +: 4];
            if (v_nib >= 4'd5) begin
                v_nib = v_nib + 4'd3;
            end
            w_adj[4*i +: 4] = v_nib;
        end
        v_nib = r_work[31:28];
        if (v_nib >= 4'd5) begin
            v_nib = v_nib + 4'd3;
        end
        w_adj[30:28] = v_nib[2:0];
    end

    assign w_workNext = {w_adj, r_shift[IN_WIDTH-1]};

    // Leading-zero suppression: a digit is shown once any higher digit is
    // nonzero; digit 0 is always shown so zero displays as "0"
    always_comb begin
        logic v_any;
        w_mask = '0;
        v_any  = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            v_any     = v_any | (|r_work[4*i +: 4]);
            w_mask[i] = v_any;
        end
        w_mask[0] = 1'b1;
    end

    // Datapath: load, shift one bit per cycle, then commit outputs atomically
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_work       <= '0;
            r_count      <= '0;
            r_sat        <= 1'b0;
            output_data  <= 32'h0000_0000;
            output_valid <= 8'h01;
            overflow     <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_shift <= in_value;
                r_work  <= '0;
                r_count <= CNT_W'(IN_WIDTH);
                r_sat   <= w_tooBig;
            end
            if (w_shiftEn) begin
                r_work  <= w_workNext;
                r_shift <= r_shift << 1;
                r_count <= r_count - CNT_W'(1);
            end
            if (w_commit) begin
                if (r_sat) begin
                    output_data  <= 32'h9999_9999;
                    output_valid <= 8'hFF;
                end else begin
                    output_data  <= r_work;
                    output_valid <= w_mask;
                end
                overflow <= r_sat;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bcd_digit_formatter.md
# bcd_digit_formatter

Converts an unsigned binary value into eight packed BCD digits plus a per-digit valid mask with leading-zero suppression. It directly feeds the seven-segment scan driver through `output_data` and `output_valid`. Conversion is iterative double-dabble, one bit per clock. A load/ready handshake accepts each new value. The last committed result is held stable until the next conversion completes.

## Interface
Parameters:
- `IN_WIDTH`, default 27: width of `in_value`; 27 bits covers 99_999_999.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_value`  in  IN_WIDTH  unsigned binary value to display; sampled only on acceptance.
- `in_load`  in  1  request to convert `in_value`.
- `in_ready`  out  1  high when idle; a load is accepted on an edge where `in_load && in_ready`.
- `output_data`  out  32  eight BCD digits; digit i is in bits [4i+3:4i], and digit 0 is least significant.
- `output_valid`  out  8  bit i is 1 when digit i is to be displayed.
- `overflow`  out  1  high when the committed result was saturated.
- `done`  out  1  one-cycle pulse when new outputs are committed.

## Operation
FSM has three states: IDLE, SHIFT, COMMIT.
- IDLE:
  - `in_ready` = 1.
  - On acceptance, latch `in_value` into the shift register, clear the 32-bit BCD work register, load the bit counter with IN_WIDTH, and go to SHIFT.
  - Set the saturate flag if `in_value` > 99_999_999.
  - `in_load` while not ready is ignored; no queuing.
- SHIFT, one iteration per cycle:
  - First, add 3 to every work nibble that is ≥ 5.
  - Then shift {work, shift register} left by one.
  - Decrement the counter.
  - After IN_WIDTH iterations, go to COMMIT.
- COMMIT, one cycle:
  - Register the work value into `output_data`.
  - Register the mask into `output_valid`.
  - Register the saturate flag into `overflow`.
  - Pulse `done`, then return to IDLE.
- Saturation: if the flag is set, commit `output_data` = 32'h9999_9999 and `output_valid` = 8'hFF, regardless of the work register.
- Mask rule:
  - valid[7] = (d7 ≠ 0).
  - valid[i] = (d_i ≠ 0) | valid[i+1] for i = 6..1.
  - valid[0] = 1 always, so a value of 0 displays a single "0".
- Arithmetic: nibble add-3 is 4-bit with no carry-out between nibbles. The shift carries the MSB of each nibble into the next. Work-register bits above digit 7 are discarded.
- Outputs change only in COMMIT or reset. They hold their previous values throughout SHIFT, so the display never shows partial results.

## Timing
- Reset values:
  - `output_data` = 0, `output_valid` = 8'h01, `overflow` = 0.
  - `done` = 0, `in_ready` = 1, FSM = IDLE.
  - Counter and work registers = 0.
- Reset in any state, including mid-SHIFT, aborts the conversion. All outputs return to their reset values on that edge.
- Acceptance edge E0. SHIFT occupies edges E1..E_IN_WIDTH. COMMIT updates the outputs on edge E_(IN_WIDTH+1), which is E28 for the default.
- `done` is high for exactly the cycle after E28. `in_ready` is low from after E0 through E28 and high again in the same cycle as `done`.
- Back-to-back operation: a load presented during the `done` cycle is accepted. Sustained throughput is one conversion per IN_WIDTH+2 cycles.
- If `rst` and `in_load` are asserted together, reset wins and nothing is accepted.

## Test plan
- Load 0 → after 28 cycles: `output_data` = 32'h0000_0000, `output_valid` = 8'h01, `overflow` = 0, `done` pulses once.
- Load 12345 → `output_data` = 32'h0001_2345, `output_valid` = 8'h1F. Outputs are unchanged (still the prior value) on every cycle before COMMIT.
- Load 99_999_999 → `output_data` = 32'h9999_9999, `output_valid` = 8'hFF, `overflow` = 0. Then load 100_000_000 → same data and mask, `overflow` = 1.
- Load 10_000_500 → `output_data` = 32'h1000_0500, `output_valid` = 8'hFF (interior zeros are valid).
- Load 42, then pulse `in_load` with 777 at cycle 10 while busy → result is 32'h0000_0042 with mask 8'h03. Then load 777 during the `done` cycle → accepted, result 32'h0000_0777 with mask 8'h07, 28 cycles later.
- Commit 12345, start loading 9, assert `rst` at cycle 15 → outputs go to reset values on that edge, `done` never pulses, and `in_ready` = 1 the next cycle.
